seq_mag_comparator: RTL and testbench

//  Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands, signed or unsigned.

---
 rtl/seq_mag_comparator_pkg.sv | 20 ++
 rtl/seq_mag_comparator_digit_cmp.sv | 21 ++
 rtl/seq_mag_comparator.sv | 150 +++++++++++++++
 tb/tb_seq_mag_comparator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mag_comparator_pkg.sv
// ---------------------------------------------------------------------------
// seq_mag_comparator_pkg
//   Shared types and helpers for the sequential magnitude comparator.
//   - state_t   : FSM state encoding (S_IDLE, S_CMP, S_DONE), 2 bits.
//   - cnt_width : width of the digit down-counter for a given digit count.
//                 It is never less than 1, so NDIG=1 still gets a legal vector.
// ---------------------------------------------------------------------------
package seq_mag_comparator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// ---------------------------------------------------------------------------
// seq_mag_comparator_digit_cmp  (the digit_cmp slice)
//   Combinational unsigned compare of one DIGIT-bit digit.
//   Ports:
//     x, y  in  DIGIT  digits to compare (already in offset-binary form)
//     gt_d  out 1      x > y
//     lt_d  out 1      x < y
// ---------------------------------------------------------------------------
module seq_mag_comparator_digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt_d,
    output logic             lt_d
);

    assign gt_d = (x > y);
    assign lt_d = (x < y);

endmodule

// File: rtl/seq_mag_comparator.sv
// ---------------------------------------------------------------------------
// seq_mag_comparator
//   Multi-cycle magnitude comparator for WIDTH-bit operands, signed or
//   unsigned. DIGIT bits are compared per cycle, most significant digit first.
//
//   Parameters:
//     WIDTH  operand width (>= 1)
//     DIGIT  bits compared per cycle; WIDTH must be a multiple of DIGIT
//
//   Ports:
//     clk          in   1      rising-edge clock
//     rst          in   1      synchronous, active-high reset
//     start        in   1      request, sampled only in IDLE
//     a, b         in   WIDTH  operands, captured on an accepted start
//     signed_mode  in   1      1 = two's-complement compare, captured on accept
//     busy         out  1      high in CMP and DONE
//     done         out  1      one-cycle pulse, results valid from this cycle
//     eq, gt, sm   out  1      a==b / a>b / a<b, held until the next done
//
//   Build option:
//     EARLY_EXIT_EN  when defined, CMP ends on the first differing digit
//                    (variable latency). Otherwise all digits are scanned
//                    (fixed latency NDIG+1). Results are the same either way.
//
//   Handshake: a request is accepted on a rising edge where the FSM is in
//   IDLE and start=1; a, b and signed_mode are captured on that edge. While
//   busy=1 start is dropped, not queued. done pulses for exactly one cycle,
//   and the next request can be accepted in the cycle after done.
// ---------------------------------------------------------------------------
module seq_mag_comparator
    import seq_mag_comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             sm
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0]    IDX_TOP  = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    idx;
    logic             diff_q;     // a differing digit has already been seen
    logic             gt_acc;
    logic             sm_acc;

    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic             gt_d;
    logic             lt_d;
    logic             diff_nxt;
    logic             gt_nxt;
    logic             sm_nxt;
    logic             finish;

    // Single digit comparator, steered by the digit counter.
    seq_mag_comparator_digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .x    (x_dig),
        .y    (y_dig),
        .gt_d (gt_d),
        .lt_d (lt_d)
    );

    always_comb begin
        x_dig = DIGIT'(a_q >> (int'(idx) * DIGIT));
        y_dig = DIGIT'(b_q >> (int'(idx) * DIGIT));

        // Once a difference is latched, later digits cannot change the result.
        diff_nxt = diff_q | gt_d | lt_d;
        gt_nxt   = diff_q ? gt_acc : gt_d;
        sm_nxt   = diff_q ? sm_acc : lt_d;

`ifdef EARLY_EXIT_EN
        finish = (idx == '0) || gt_d || lt_d;
`else
        finish = (idx == '0);
`endif

        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CMP;
            S_CMP:   if (finish) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            diff_q <= 1'b0;
            gt_acc <= 1'b0;
            sm_acc <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            sm     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Flipping the sign bit maps two's complement onto
                        // offset binary, so one unsigned compare serves both.
                        a_q    <= a ^ (signed_mode ? MSB_MASK : '0);
                        b_q    <= b ^ (signed_mode ? MSB_MASK : '0);
                        idx    <= IDX_TOP;
                        diff_q <= 1'b0;
                        gt_acc <= 1'b0;
                        sm_acc <= 1'b0;
                    end
                end
                S_CMP: begin
                    diff_q <= diff_nxt;
                    gt_acc <= gt_nxt;
                    sm_acc <= sm_nxt;
                    if (idx != '0) idx <= idx - CW'(1);
                    if (finish) begin
                        eq <= ~diff_nxt;
                        gt <= gt_nxt;
                        sm <= sm_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_mag_comparator
//   Bench for seq_mag_comparator: an 8-bit / 2-bit-digit instance and a
//   4-bit / 4-bit-digit (single digit) instance sharing one clock. Expected
//   results and latencies come from an arithmetic reference model.
//   Build with EARLY_EXIT_EN defined to match an early-exit DUT build.
// ---------------------------------------------------------------------------
module tb_seq_mag_comparator;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int W4 = 4;
    localparam int D4 = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          busy, done, eq, gt, sm;

    logic          start4;
    logic [W4-1:0] a4;
    logic [W4-1:0] b4;
    logic          signed_mode4;
    logic          busy4, done4, eq4, gt4, sm4;

    seq_mag_comparator #(.WIDTH(W), .DIGIT(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .gt          (gt),
        .sm          (sm)
    );

    seq_mag_comparator #(.WIDTH(W4), .DIGIT(D4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start4),
        .a           (a4),
        .b           (b4),
        .signed_mode (signed_mode4),
        .busy        (busy4),
        .done        (done4),
        .eq          (eq4),
        .gt          (gt4),
        .sm          (sm4)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];   // {eq, gt, sm}

    // Reference model: integer compare of the operand values, plus the
    // start-to-done latency derived from the digits of the offset-binary values.
    function automatic void model(input int av, input int bv, input int w, input int d,
                                  input bit tsm, output logic [2:0] r, output int lat);
        int va, vb, ua, ub, nd;
        nd = w / d;
        va = av;
        vb = bv;
        if (tsm) begin
            if (va >= (1 << (w - 1))) va = va - (1 << w);
            if (vb >= (1 << (w - 1))) vb = vb - (1 << w);
        end
        if (va == vb)     r = 3'b100;
        else if (va > vb) r = 3'b010;
        else              r = 3'b001;
        ua  = tsm ? va + (1 << (w - 1)) : va;
        ub  = tsm ? vb + (1 << (w - 1)) : vb;
        lat = nd + 1;
`ifdef EARLY_EXIT_EN
        for (int j = 0; j < nd; j++) begin
            int sc;
            sc = 1 << (d * (nd - 1 - j));
            if (((ua / sc) % (1 << d)) != ((ub / sc) % (1 << d))) begin
                lat = j + 2;
                break;
            end
        end
`else
        if (ua < 0 || ub < 0) lat = -1;
`endif
    endfunction

    // ---------------- drivers ----------------
    // Called just after a falling edge while the 8-bit DUT is idle. Returns one
    // cycle after done, i.e. in the earliest cycle a new start is accepted.
    task automatic run8(input logic [W-1:0] av, input logic [W-1:0] bv, input logic tsm,
                        input bit garbage, input string tag);
        logic [2:0] er;
        logic [2:0] got;
        int lat;
        model(int'(av), int'(bv), W, D, tsm, er, lat);
        exp_q.push_back(er);
        start = 1'b1; a = av; b = bv; signed_mode = tsm;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (garbage && k <= 3) begin
                start = 1'b1; a = '0; b = 8'hFF; signed_mode = ~tsm;
            end else begin
                start = 1'b0;
            end
            n_checks++;
            if (busy !== 1'b1 || done !== (k == lat)) begin
                n_fail++;
                $display("FAIL %s busy/done at T+%0d: got busy=%b done=%b, want busy=1 done=%0d",
                         tag, k, busy, done, (k == lat));
            end
        end
        got = {eq, gt, sm};
        er  = exp_q.pop_front();
        n_checks++;
        if (got !== er) begin
            n_fail++;
            $display("FAIL %s result a=%h b=%h s=%b: got eq/gt/sm=%b want %b", tag, av, bv, tsm, got, er);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {eq, gt, sm} !== er) begin
            n_fail++;
            $display("FAIL %s after done: got busy=%b done=%b res=%b want busy=0 done=0 res=%b",
                     tag, busy, done, {eq, gt, sm}, er);
        end
    endtask

    task automatic run4(input logic [W4-1:0] av, input logic [W4-1:0] bv, input logic tsm,
                        input string tag);
        logic [2:0] er;
        int lat;
        model(int'(av), int'(bv), W4, D4, tsm, er, lat);
        exp_q.push_back(er);
        start4 = 1'b1; a4 = av; b4 = bv; signed_mode4 = tsm;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            n_checks++;
            if (busy4 !== 1'b1 || done4 !== (k == lat)) begin
                n_fail++;
                $display("FAIL %s busy/done at T+%0d: got busy=%b done=%b, want busy=1 done=%0d",
                         tag, k, busy4, done4, (k == lat));
            end
        end
        er = exp_q.pop_front();
        n_checks++;
        if ({eq4, gt4, sm4} !== er) begin
            n_fail++;
            $display("FAIL %s result a=%h b=%h s=%b: got eq/gt/sm=%b want %b",
                     tag, av, bv, tsm, {eq4, gt4, sm4}, er);
        end
        @(negedge clk);
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after done: got busy=%b done=%b want 0 0", tag, busy4, done4);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; signed_mode4 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, eq, gt, sm} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy/done/eq/gt/sm=%b want 00000", {busy, done, eq, gt, sm});
        end
        n_checks++;
        if ({busy4, done4, eq4, gt4, sm4} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_w4: got busy/done/eq/gt/sm=%b want 00000", {busy4, done4, eq4, gt4, sm4});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run8(8'h35, 8'h15, 1'b0, 1'b0, "case1_gt");
        run8(8'h99, 8'h99, 1'b0, 1'b0, "case2_eq");
        run8(8'h80, 8'h7F, 1'b1, 1'b0, "case3_signed");
        run8(8'h80, 8'h7F, 1'b0, 1'b0, "case3_unsigned");
        run8(8'h15, 8'h35, 1'b0, 1'b0, "lsb_side_sm");
        run8(8'h34, 8'h35, 1'b0, 1'b0, "last_digit_sm");
        run8(8'hFF, 8'h01, 1'b1, 1'b0, "signed_neg1_vs_1");
    endtask

    task automatic test_ignore_start();
        run8(8'h35, 8'h15, 1'b0, 1'b1, "case4_ignored_start");
    endtask

    task automatic test_abort();
        run8(8'h99, 8'h99, 1'b0, 1'b0, "abort_setup");
        start = 1'b1; a = 8'h99; b = 8'h99; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, eq, gt, sm} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy/done/eq/gt/sm=%b want 00000", {busy, done, eq, gt, sm});
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done cycle %0d: got busy=%b done=%b want 0 0", k, busy, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        run8(8'h00, 8'hFF, 1'b0, 1'b0, "b2b_0");
        run8(8'hFF, 8'h00, 1'b0, 1'b0, "b2b_1");
        run8(8'h00, 8'hFF, 1'b1, 1'b0, "b2b_2");
        run8(8'h7F, 8'h7F, 1'b1, 1'b0, "b2b_3");
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic rs;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ W'($urandom_range(0, 3));
                2:       rb = ra ^ W'($urandom_range(0, 15));
                default: rb = W'($urandom_range(0, 255));
            endcase
            rs = 1'($urandom_range(0, 1));
            run8(ra, rb, rs, 1'b0, "random");
        end
    endtask

    task automatic test_single_digit();
        run4(4'd3,  4'd1,  1'b0, "nd1_3_1");
        run4(4'd10, 4'd3,  1'b0, "nd1_10_3");
        run4(4'd3,  4'd10, 1'b0, "nd1_3_10");
        run4(4'd15, 4'd0,  1'b0, "nd1_15_0");
        run4(4'd9,  4'd9,  1'b0, "nd1_9_9");
        for (int i = 0; i < 8; i++)
            run4(W4'($urandom_range(0, 15)), W4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), "nd1_random");
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        test_single_digit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: every driver loop is bounded, this guards against a stuck clock.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
